uart_rx_frontend: RTL and testbench
===================================

Name: uart_rx_frontend

Overview:
- UART receiver on the write side of the dual-clock UART CDC path: samples async serial line `rx_in` in the clk_rx domain using 16x oversampling and a baud tick.
- Deframes 8N1 characters and writes each good byte into the rx→tx FIFO with a single-cycle write strobe.
- Flags framing errors and FIFO overruns.

Parameters:
- CLK_FREQ, 50_000_000, clk_rx frequency in Hz.
- BAUD, 115200, serial bit rate.
- OVERSAMPLE, 16, ticks per bit; must be even and >= 4.
- DATA_WIDTH, 8, data bits per frame, sent LSB first.

Ports:
- clk_rx  input  1  receive/write clock.
- rst  input  1  reset.
- rx_in  input  1  async serial line, idle high.
- fifo_full  input  1  FIFO cannot accept a write this cycle.
- wr_en  output  1  one-cycle FIFO write strobe.
- wr_data  output  DATA_WIDTH  byte to FIFO; valid when wr_en=1, held until the next write.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: good byte dropped because fifo_full=1.
- busy  output  1  high from start detection until return to IDLE.

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk_rx. On reset: wr_en=0, wr_data=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, all counters 0.
- Synchronizer: 2-flop synchronizer on rx_in, flops reset to 0. rx_prev holds the previous synced value and resets to 0. A start edge is synced=0 and rx_prev=1. After reset, a line that stays low is never taken as a start.
- Baud tick:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation, minimum 1.
  - tick is a 1-cycle pulse every DIV clk_rx cycles, free-running from reset.
- Sampling: sample counter scnt (0..OVERSAMPLE-1) advances only on tick. bit_idx counts 0..DATA_WIDTH-1.
- FSM:
  - IDLE: busy=0. On a start edge (checked every clk_rx cycle): scnt=0, go to START, busy=1.
  - START: on the tick where scnt==OVERSAMPLE/2-1 (mid start bit):
    - synced=0: scnt=0, bit_idx=0, go to DATA.
    - synced=1: glitch; go to IDLE with no error.
  - DATA: on the tick where scnt==OVERSAMPLE-1 (mid bit): shift synced into the shift register MSB, shifting right (LSB-first assembly); scnt=0. After bit DATA_WIDTH-1, go to STOP.
  - STOP: on the tick where scnt==OVERSAMPLE-1 (mid stop bit):
    - synced=1 and fifo_full=0: wr_en=1 for one cycle, wr_data=shift register.
    - synced=1 and fifo_full=1: overrun=1 for one cycle; no write; wr_data unchanged.
    - synced=0: frame_err=1 for one cycle; no write.
    - In every case, go to IDLE next cycle. The next start needs a fresh 1→0 edge, so a break (line held low) produces exactly one frame_err.
- Latency: wr_en asserts 1 clk_rx after the mid-stop-bit tick. This is about (1.5 + DATA_WIDTH) bit times + 3 cycles after the rx_in falling edge.
- Back-to-back frames: a start edge arriving in the cycle the FSM enters IDLE is accepted. No minimum idle gap beyond the half stop bit.
- At most one of wr_en, overrun, frame_err is high in any cycle.
- Reset mid-frame aborts the frame silently: no pulses, partial byte discarded.

Decomposition:
- Package uart_pkg:
  - state encoding: IDLE=0, START=1, DATA=2, STOP=3;
  - function computing DIV from CLK_FREQ/BAUD/OVERSAMPLE;
  - default parameter constants.
- Sub-module uart_baud_tick: parameter DIV; ports clk_rx, rst, tick. Reused by the future TX side.

Test Plan (CLK_FREQ=6_400_000, BAUD=100_000, OVERSAMPLE=16 → DIV=4, 64 clk/bit):
- Send 0xA5, 8N1, after 2 idle bits → exactly one wr_en pulse with wr_data=0xA5, 610±4 cycles after the falling edge; frame_err=0, overrun=0.
- Send 0x00, 0xFF, 0x55 back-to-back with no idle gap → three wr_en pulses, data in order 0x00, 0xFF, 0x55; no errors.
- rx_in low for 16 clk then high → no wr_en, no frame_err; busy high, then low within 40 clk.
- Send 0x3C with stop bit=0 → one frame_err pulse, no wr_en. Then line high for 1 bit, send 0x81 → wr_en with wr_data=0x81.
- fifo_full=1 throughout the 0x5A stop bit, previous byte 0x81 → one overrun pulse, no wr_en, wr_data stays 0x81.
- Assert rst after 4 data bits of 0xC3, release while line still low, then idle 2 bits, send 0x12 → all outputs 0 during reset, no pulse for the aborted frame, one wr_en with wr_data=0x12.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART CDC path: receiver state encoding,
// default line parameters and the baud divider calculation.
package uart_pkg;

    // Default line settings used when a parent does not override them.
    localparam int DEF_CLK_FREQ  = 50_000_000;
    localparam int DEF_BAUD      = 115_200;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_WIDTH = 8;

    // Receiver FSM encoding; values are fixed so external checkers can decode them.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per oversample tick, truncated, never below 1.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle pulse every DIV clocks.
// Shared between the RX and TX sides of the UART.
module uart_baud_tick #(
    parameter int DIV = 4
) (
    input  logic clk_rx,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter: counts 0..DIV-1 and wraps, starting from reset.
    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receiver front end (clk_rx domain): synchronises rx_in, deframes
// 8N1-style characters with oversampled mid-bit sampling and pushes each
// good byte into the rx->tx FIFO.
//
// FIFO write handshake: a byte is written in every cycle where wr_en=1;
// wr_en is raised only if fifo_full was 0 on the mid-stop-bit tick. If the
// FIFO was full at that point the byte is dropped and overrun pulses instead.
// wr_data holds the last written byte between writes.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_rx,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  fifo_full,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [SW-1:0] SCNT_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIDX_LAST = BW'(DATA_WIDTH - 1);

    // Synchroniser and edge detect
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic start_edge;

    // Oversample tick
    logic tick;

    // FSM state and datapath registers
    rx_state_t             state,   state_n;
    logic [SW-1:0]         scnt,    scnt_n;
    logic [BW-1:0]         bit_idx, bit_idx_n;
    logic [DATA_WIDTH-1:0] shreg,   shreg_n;
    logic [DATA_WIDTH-1:0] wr_data_n;
    logic                  wr_en_n;
    logic                  frame_err_n;
    logic                  overrun_n;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk_rx (clk_rx),
        .rst    (rst),
        .tick   (tick)
    );

    // Two-flop synchroniser plus one-cycle history for falling-edge detection.
    // Everything resets to 0 so a line held low through reset never looks like a start.
    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b0;
            rx_sync <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = rx_prev & ~rx_sync;

    // State, counters and registered outputs.
    always_ff @(posedge clk_rx or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            scnt      <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            scnt      <= scnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            wr_en     <= wr_en_n;
            wr_data   <= wr_data_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
        end
    end

    // Next-state logic: start qualification at mid start bit, LSB-first
    // data capture at mid bit, stop-bit check and FIFO write decision.
    always_comb begin
        state_n     = state;
        scnt_n      = scnt;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        wr_data_n   = wr_data;
        wr_en_n     = 1'b0;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;

        case (state)
            IDLE: begin
                if (start_edge) begin
                    scnt_n  = '0;
                    state_n = START;
                end
            end

            START: begin
                if (tick) begin
                    if (scnt == SCNT_MID) begin
                        scnt_n = '0;
                        if (!rx_sync) begin
                            bit_idx_n = '0;
                            state_n   = DATA;
                        end else begin
                            // Line went back high: treat as noise, no error.
                            state_n = IDLE;
                        end
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (scnt == SCNT_LAST) begin
                        scnt_n  = '0;
                        shreg_n = {rx_sync, shreg[DATA_WIDTH-1:1]};
                        if (bit_idx == BIDX_LAST) begin
                            state_n = STOP;
                        end else begin
                            bit_idx_n = bit_idx + 1'b1;
                        end
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (scnt == SCNT_LAST) begin
                        scnt_n  = '0;
                        state_n = IDLE;
                        if (!rx_sync) begin
                            frame_err_n = 1'b1;
                        end else if (fifo_full) begin
                            overrun_n = 1'b1;
                        end else begin
                            wr_en_n   = 1'b1;
                            wr_data_n = shreg;
                        end
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Testbench for uart_rx_frontend at 6.4 MHz / 100 kbaud / x16 (64 clk per bit).
module tb_uart_rx_frontend;

  localparam int CLK_FREQ   = 6_400_000;
  localparam int BAUD       = 100_000;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_WIDTH = 8;
  localparam int BIT_CYC    = CLK_FREQ / BAUD;
  localparam int LAT_NOM    = 610;
  localparam int LAT_TOL    = 4;

  // ---------------- clock / reset / DUT ----------------
  logic                  clk_rx = 1'b0;
  logic                  rst;
  logic                  rx_in;
  logic                  fifo_full;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  frame_err;
  logic                  overrun;
  logic                  busy;

  always #5 clk_rx = ~clk_rx;

  uart_rx_frontend #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .clk_rx    (clk_rx),
    .rst       (rst),
    .rx_in     (rx_in),
    .fifo_full (fifo_full),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // ---------------- counters and observation ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk_rx) cyc <= cyc + 1;

  logic [DATA_WIDTH-1:0] wr_q[$];
  int                    wr_t_q[$];
  int                    fe_cnt   = 0;
  int                    ov_cnt   = 0;
  int                    excl_cnt = 0;

  always @(negedge clk_rx) begin
    if (!rst) begin
      if (wr_en) begin
        wr_q.push_back(wr_data);
        wr_t_q.push_back(cyc);
      end
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
      if ((int'(wr_en) + int'(frame_err) + int'(overrun)) > 1) excl_cnt <= excl_cnt + 1;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_WIDTH-1:0] exp_q[$];
  int                    exp_fe   = 0;
  int                    exp_ov   = 0;
  logic [DATA_WIDTH-1:0] exp_last = '0;
  int                    wr_rd    = 0;
  int                    t_fall   = 0;

  // Outcome of one frame from the line-level rules: bad stop -> frame error,
  // good stop with full FIFO -> overrun, otherwise the byte is written.
  task automatic model_frame(input logic [DATA_WIDTH-1:0] d, input logic stop_b, input logic full);
    if (!stop_b) exp_fe++;
    else if (full) exp_ov++;
    else begin
      exp_q.push_back(d);
      exp_last = d;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_bits(input int n);
    rx_in = 1'b1;
    repeat (n * BIT_CYC) @(negedge clk_rx);
  endtask

  task automatic drive_frame(input logic [DATA_WIDTH-1:0] d, input logic stop_b);
    rx_in  = 1'b0;
    t_fall = cyc;
    repeat (BIT_CYC) @(negedge clk_rx);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      rx_in = d[i];
      repeat (BIT_CYC) @(negedge clk_rx);
    end
    rx_in = stop_b;
    repeat (BIT_CYC) @(negedge clk_rx);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    rx_in = 1'b1;
    fifo_full = 1'b0;
    repeat (3) @(negedge clk_rx);
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b, expected 0", wr_en); end
    n_vec++; if (wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data: got %02h, expected 00", wr_data); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    rst = 1'b0;
    idle_bits(2);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_single;
    logic [DATA_WIDTH-1:0] got, want;
    int lat;
    drive_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1, 1'b0);
    idle_bits(2);
    n_vec++;
    if (wr_q.size() != wr_rd + 1) begin
      n_err++; $display("FAIL single_write_count: got %0d, expected 1", wr_q.size() - wr_rd);
    end else begin
      lat = wr_t_q[wr_rd] - t_fall;
      n_vec++;
      if (lat < LAT_NOM - LAT_TOL || lat > LAT_NOM + LAT_TOL) begin
        n_err++; $display("FAIL single_latency: got %0d cycles, expected %0d +/- %0d", lat, LAT_NOM, LAT_TOL);
      end
    end
    while (wr_rd < wr_q.size()) begin
      got = wr_q[wr_rd]; wr_rd++;
      n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL single_extra_write: got %02h, expected none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin n_err++; $display("FAIL single_data: got %02h, expected %02h", got, want); end
      end
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL single_missing_write: %0d outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    n_vec++; if (fe_cnt != exp_fe) begin n_err++; $display("FAIL single_frame_err: got %0d, expected %0d", fe_cnt, exp_fe); end
    n_vec++; if (ov_cnt != exp_ov) begin n_err++; $display("FAIL single_overrun: got %0d, expected %0d", ov_cnt, exp_ov); end
  endtask

  task automatic test_back_to_back;
    logic [DATA_WIDTH-1:0] got, want;
    logic [DATA_WIDTH-1:0] pat [3];
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55;
    for (int i = 0; i < 3; i++) begin
      drive_frame(pat[i], 1'b1);
      model_frame(pat[i], 1'b1, 1'b0);
    end
    idle_bits(2);
    while (wr_rd < wr_q.size()) begin
      got = wr_q[wr_rd]; wr_rd++;
      n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL b2b_extra_write: got %02h, expected none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin n_err++; $display("FAIL b2b_data: got %02h, expected %02h", got, want); end
      end
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_missing_write: %0d outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    n_vec++; if (fe_cnt != exp_fe) begin n_err++; $display("FAIL b2b_frame_err: got %0d, expected %0d", fe_cnt, exp_fe); end
    n_vec++; if (ov_cnt != exp_ov) begin n_err++; $display("FAIL b2b_overrun: got %0d, expected %0d", ov_cnt, exp_ov); end
  endtask

  task automatic test_glitch;
    logic seen_busy;
    logic low_ok;
    int   w_before;
    w_before  = wr_q.size();
    seen_busy = 1'b0;
    low_ok    = 1'b0;
    rx_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_rx);
      if (busy === 1'b1) seen_busy = 1'b1;
    end
    rx_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_rx);
      if (busy === 1'b1) seen_busy = 1'b1;
      if (seen_busy && busy === 1'b0) begin
        low_ok = 1'b1;
        break;
      end
    end
    idle_bits(1);
    n_vec++; if (seen_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_high: got %b, expected 1", seen_busy); end
    n_vec++; if (low_ok !== 1'b1) begin n_err++; $display("FAIL glitch_busy_low: got %b, expected 1 within 40 clk", low_ok); end
    n_vec++; if (wr_q.size() != w_before) begin n_err++; $display("FAIL glitch_write: got %0d writes, expected 0", wr_q.size() - w_before); end
    n_vec++; if (fe_cnt != exp_fe) begin n_err++; $display("FAIL glitch_frame_err: got %0d, expected %0d", fe_cnt, exp_fe); end
  endtask

  task automatic test_frame_err;
    logic [DATA_WIDTH-1:0] got, want;
    drive_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b0);
    idle_bits(1);
    n_vec++; if (fe_cnt != exp_fe) begin n_err++; $display("FAIL ferr_count: got %0d, expected %0d", fe_cnt, exp_fe); end
    n_vec++; if (wr_q.size() != wr_rd) begin n_err++; $display("FAIL ferr_write: got %0d writes, expected 0", wr_q.size() - wr_rd); end
    drive_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1, 1'b0);
    idle_bits(2);
    while (wr_rd < wr_q.size()) begin
      got = wr_q[wr_rd]; wr_rd++;
      n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL ferr_extra_write: got %02h, expected none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin n_err++; $display("FAIL ferr_recover_data: got %02h, expected %02h", got, want); end
      end
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ferr_missing_write: %0d outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    n_vec++; if (fe_cnt != exp_fe) begin n_err++; $display("FAIL ferr_count_after: got %0d, expected %0d", fe_cnt, exp_fe); end
  endtask

  task automatic test_overrun;
    fifo_full = 1'b1;
    drive_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1, 1'b1);
    fifo_full = 1'b0;
    idle_bits(2);
    n_vec++; if (ov_cnt != exp_ov) begin n_err++; $display("FAIL ovr_count: got %0d, expected %0d", ov_cnt, exp_ov); end
    n_vec++; if (wr_q.size() != wr_rd) begin n_err++; $display("FAIL ovr_write: got %0d writes, expected 0", wr_q.size() - wr_rd); end
    n_vec++; if (wr_data !== exp_last) begin n_err++; $display("FAIL ovr_wr_data_hold: got %02h, expected %02h", wr_data, exp_last); end
    n_vec++; if (fe_cnt != exp_fe) begin n_err++; $display("FAIL ovr_frame_err: got %0d, expected %0d", fe_cnt, exp_fe); end
  endtask

  task automatic test_reset_midframe;
    logic [DATA_WIDTH-1:0] got, want;
    logic [DATA_WIDTH-1:0] d;
    d = 8'hC3;
    rx_in = 1'b0;
    repeat (BIT_CYC) @(negedge clk_rx);
    for (int i = 0; i < 4; i++) begin
      rx_in = d[i];
      repeat (BIT_CYC) @(negedge clk_rx);
    end
    rx_in = d[4];
    repeat (10) @(negedge clk_rx);
    rst = 1'b1;
    repeat (3) @(negedge clk_rx);
    n_vec++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rstmid_wr_en: got %b, expected 0", wr_en); end
    n_vec++; if (wr_data !== 8'h00) begin n_err++; $display("FAIL rstmid_wr_data: got %02h, expected 00", wr_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
    n_vec++; if ((frame_err | overrun) !== 1'b0) begin n_err++; $display("FAIL rstmid_pulses: got %b%b, expected 00", frame_err, overrun); end
    exp_last = '0;
    rst = 1'b0;
    repeat (BIT_CYC) @(negedge clk_rx);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_low_line_busy: got %b, expected 0", busy); end
    idle_bits(2);
    n_vec++; if (wr_q.size() != wr_rd || fe_cnt != exp_fe || ov_cnt != exp_ov) begin
      n_err++; $display("FAIL rstmid_aborted: got %0d writes %0d ferr %0d ovr, expected 0 %0d %0d", wr_q.size() - wr_rd, fe_cnt, ov_cnt, exp_fe, exp_ov);
    end
    drive_frame(8'h12, 1'b1);
    model_frame(8'h12, 1'b1, 1'b0);
    idle_bits(2);
    while (wr_rd < wr_q.size()) begin
      got = wr_q[wr_rd]; wr_rd++;
      n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL rstmid_extra_write: got %02h, expected none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin n_err++; $display("FAIL rstmid_data: got %02h, expected %02h", got, want); end
      end
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rstmid_missing_write: %0d outstanding, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_random;
    logic [DATA_WIDTH-1:0] got, want;
    logic [DATA_WIDTH-1:0] d;
    logic stop_b, full;
    int gap;
    for (int n = 0; n < 12; n++) begin
      d      = DATA_WIDTH'($urandom_range(0, 255));
      stop_b = ($urandom_range(0, 3) != 0);
      full   = ($urandom_range(0, 3) == 0);
      fifo_full = full;
      drive_frame(d, stop_b);
      model_frame(d, stop_b, full);
      fifo_full = 1'b0;
      gap = stop_b ? $urandom_range(0, 2) : 1;
      if (gap > 0) idle_bits(gap);
    end
    idle_bits(2);
    while (wr_rd < wr_q.size()) begin
      got = wr_q[wr_rd]; wr_rd++;
      n_vec++;
      if (exp_q.size() == 0) begin n_err++; $display("FAIL rand_extra_write: got %02h, expected none", got); end
      else begin
        want = exp_q.pop_front();
        if (got !== want) begin n_err++; $display("FAIL rand_data: got %02h, expected %02h", got, want); end
      end
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_missing_write: %0d outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    n_vec++; if (fe_cnt != exp_fe) begin n_err++; $display("FAIL rand_frame_err: got %0d, expected %0d", fe_cnt, exp_fe); end
    n_vec++; if (ov_cnt != exp_ov) begin n_err++; $display("FAIL rand_overrun: got %0d, expected %0d", ov_cnt, exp_ov); end
    n_vec++; if (wr_data !== exp_last) begin n_err++; $display("FAIL rand_wr_data_hold: got %02h, expected %02h", wr_data, exp_last); end
  endtask

  task automatic test_exclusive;
    n_vec++;
    if (excl_cnt != 0) begin n_err++; $display("FAIL exclusive_pulses: got %0d overlapping cycles, expected 0", excl_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    rx_in = 1'b1;
    fifo_full = 1'b0;
    @(negedge clk_rx);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_reset_midframe;
    test_random;
    test_exclusive;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
